hazard_ctrl_unit: RTL and testbench

Pipeline hazard controller that drives the stall/flush/enable side of the ID/EX pipeline register and the PC and IF/ID stage. It watches the EX-stage control fields (the ID/EX register outputs) and the ID-stage operands, inserts load-use bubbles, flushes on taken branches, and freezes the pipeline during multicycle data-memory waits. A watchdog halts the pipeline with a sticky error when a freeze lasts too long.

---
 rtl/hazard_pkg.sv | 15 +
 rtl/hazard_sat_counter.sv | 19 +
 rtl/hazard_ctrl_unit.sv | 130 +++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and defaults for the ID/EX hazard controller.
package hazard_pkg;

    typedef enum logic [2:0] {
        HZ_RUN       = 3'd0,
        HZ_LOAD_USE  = 3'd1,
        HZ_MEM_WAIT  = 3'd2,
        HZ_FLUSH     = 3'd3,
        HZ_ERROR     = 3'd4
    } hz_state_t;

    localparam int HZ_STALL_TIMEOUT = 10;
    localparam int HZ_CNT_W         = 32;

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module hazard_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Stall/flush/enable control for PC, IF/ID and ID/EX with a freeze watchdog.
// Performance counters exist only when HAZARD_STATS_EN is defined.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int STALL_TIMEOUT = HZ_STALL_TIMEOUT,
    parameter int CNT_W         = HZ_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rt,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_stall,
    output logic             idex_flush,
    output logic             exmem_stall,
    output hz_state_t        hz_state,
    output logic             hazard_error,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int FCW = $clog2(STALL_TIMEOUT + 1);

    hz_state_t      state;
    hz_state_t      state_nxt;
    logic [FCW-1:0] freeze_cnt;
    logic           load_use;
    logic           mem_wait;
    logic           frozen;
    logic           timeout_hit;

    assign load_use = ex_memread && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (ex_rt == id_rt));
    assign mem_wait = dmem_req && !dmem_ready;

    // This cycle is frozen; if it is the STALL_TIMEOUT-th in a row, trip the watchdog.
    assign frozen      = !pc_en;
    assign timeout_hit = frozen && (freeze_cnt >= FCW'(STALL_TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= HZ_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = HZ_RUN;
        if ((state == HZ_ERROR) || timeout_hit) begin
            state_nxt = HZ_ERROR;
        end else if (mem_wait) begin
            state_nxt = HZ_MEM_WAIT;
        end else if (branch_taken) begin
            state_nxt = HZ_FLUSH;
        end else if (load_use) begin
            state_nxt = HZ_LOAD_USE;
        end
    end

    // A branch seen during a memory wait is deliberately dropped here: EX is held,
    // so the same branch is still presented on the first non-wait cycle.
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_stall  = 1'b0;
        idex_flush  = 1'b0;
        exmem_stall = 1'b0;
        if ((state == HZ_ERROR) || mem_wait) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_stall  = 1'b1;
            exmem_stall = 1'b1;
        end else if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
        end else if (load_use) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_flush  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            freeze_cnt   <= '0;
            hazard_error <= 1'b0;
        end else begin
            if (!frozen) begin
                freeze_cnt <= '0;
            end else if (freeze_cnt != FCW'(STALL_TIMEOUT)) begin
                freeze_cnt <= freeze_cnt + 1'b1;
            end
            if (state_nxt == HZ_ERROR) begin
                hazard_error <= 1'b1;
            end
        end
    end

    assign hz_state = state;

`ifdef HAZARD_STATS_EN
    hazard_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (frozen),
        .count   (stall_count)
    );

    hazard_sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (idex_flush),
        .count   (flush_count)
    );
`else
    assign stall_count = '0;
    assign flush_count = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit: driver pushes expected responses, monitor checks mid-cycle.
module tb_hazard_ctrl_unit;
    import hazard_pkg::*;

    localparam int TIMEOUT = 10;
    localparam int CW      = 4;
    localparam longint CMAX = (64'd1 << CW) - 1;
`ifdef HAZARD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [4:0]    id_rs = '0, id_rt = '0, ex_rt = '0;
    logic          ex_memread = 1'b0, branch_taken = 1'b0, dmem_req = 1'b0, dmem_ready = 1'b0;
    logic          pc_en, ifid_en, ifid_flush, idex_stall, idex_flush, exmem_stall;
    hz_state_t     hz_state;
    logic          hazard_error;
    logic [CW-1:0] stall_count, flush_count;

    hazard_ctrl_unit #(.STALL_TIMEOUT(TIMEOUT), .CNT_W(CW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .ex_memread   (ex_memread),
        .ex_rt        (ex_rt),
        .branch_taken (branch_taken),
        .dmem_req     (dmem_req),
        .dmem_ready   (dmem_ready),
        .pc_en        (pc_en),
        .ifid_en      (ifid_en),
        .ifid_flush   (ifid_flush),
        .idex_stall   (idex_stall),
        .idex_flush   (idex_flush),
        .exmem_stall  (exmem_stall),
        .hz_state     (hz_state),
        .hazard_error (hazard_error),
        .stall_count  (stall_count),
        .flush_count  (flush_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit     pc_en, ifid_en, ifid_flush, idex_stall, idex_flush, exmem_stall;
        int     st;
        bit     err;
        longint scnt, fcnt;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: pipeline status as seen by the spec rules.
    int     m_st  = 0;
    bit     m_err = 1'b0;
    int     m_run = 0;
    longint m_sc  = 0;
    longint m_fc  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("pc_en",        64'(pc_en),        64'(e.pc_en));
            chk("ifid_en",      64'(ifid_en),      64'(e.ifid_en));
            chk("ifid_flush",   64'(ifid_flush),   64'(e.ifid_flush));
            chk("idex_stall",   64'(idex_stall),   64'(e.idex_stall));
            chk("idex_flush",   64'(idex_flush),   64'(e.idex_flush));
            chk("exmem_stall",  64'(exmem_stall),  64'(e.exmem_stall));
            chk("hz_state",     64'(hz_state),     64'(e.st));
            chk("hazard_error", 64'(hazard_error), 64'(e.err));
            chk("stall_count",  64'(stall_count),  64'(e.scnt));
            chk("flush_count",  64'(flush_count),  64'(e.fcnt));
        end
    end

    task automatic step(input bit rn, input bit mr, input logic [4:0] ert,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input bit br, input bit req, input bit rdy);
        exp_t e;
        bit lu, mw, freeze, fl, lub, fz;
        @(posedge clk);
        #1;
        reset_n = rn; ex_memread = mr; ex_rt = ert; id_rs = rs; id_rt = rt;
        branch_taken = br; dmem_req = req; dmem_ready = rdy;

        if (!rn) begin
            m_st = 0; m_err = 1'b0; m_run = 0; m_sc = 0; m_fc = 0;
        end
        lu     = mr && (ert != 0) && ((ert == rs) || (ert == rt));
        mw     = req && !rdy;
        freeze = (m_st == 4) || mw;
        fl     = !freeze && br;
        lub    = !freeze && !br && lu;

        e.pc_en       = !(freeze || lub);
        e.ifid_en     = !(freeze || lub);
        e.ifid_flush  = fl;
        e.idex_stall  = freeze;
        e.exmem_stall = freeze;
        e.idex_flush  = fl || lub;
        e.st          = m_st;
        e.err         = m_err;
        e.scnt        = STATS ? m_sc : 0;
        e.fcnt        = STATS ? m_fc : 0;
        q.push_back(e);

        if (rn) begin
            fz    = !e.pc_en;
            m_run = fz ? m_run + 1 : 0;
            if (m_st == 4 || (fz && m_run >= TIMEOUT)) m_st = 4;
            else if (mw)                                m_st = 2;
            else if (br)                                m_st = 3;
            else if (lu)                                m_st = 1;
            else                                        m_st = 0;
            m_err = (m_st == 4);
            if (fz && m_sc < CMAX)           m_sc++;
            if (e.idex_flush && m_fc < CMAX) m_fc++;
        end
    endtask

    task automatic idle();
        step(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 5, 5, 0, 1, 1, 0);
        idle();

        // load-use, then ex_rt = 0 (no hazard)
        step(1, 1, 5, 5, 0, 0, 0, 0);
        idle();
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 7, 1, 7, 0, 0, 0);
        idle();

        // taken branch
        step(1, 0, 0, 0, 0, 1, 0, 0);
        idle();

        // three-cycle memory wait
        repeat (3) step(1, 0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 1, 1);
        idle();

        // wait + branch + load-use together, branch applied once the wait ends
        repeat (2) step(1, 1, 3, 3, 0, 1, 1, 0);
        step(1, 1, 3, 3, 0, 1, 1, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        idle();

        // watchdog into ERROR, stays frozen, reset recovers
        repeat (12) step(1, 0, 0, 0, 0, 0, 1, 0);
        repeat (3)  step(1, 0, 0, 0, 0, 1, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        idle();

        // counter saturation: 20 non-consecutive stall cycles
        repeat (20) begin
            step(1, 1, 9, 2, 9, 0, 0, 0);
            idle();
        end
        step(0, 0, 0, 0, 0, 0, 0, 0);

        // randomized traffic with occasional long waits and resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                int len;
                len = $urandom_range(8, 13);
                for (int k = 0; k < len; k++)
                    step(1, 0, 0, 0, 0, $urandom_range(0, 1) == 1, 1, 0);
            end else begin
                step($urandom_range(0, 79) != 0,
                     $urandom_range(0, 2) == 0,
                     5'($urandom_range(0, 7)),
                     5'($urandom_range(0, 7)),
                     5'($urandom_range(0, 7)),
                     $urandom_range(0, 4) == 0,
                     $urandom_range(0, 1) == 1,
                     $urandom_range(0, 2) != 0);
            end
        end

        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
